// File: rtl/serial_subtractor_if.sv
// Operand/result bundle between a controller and the bit-serial subtractor.
// Latency: n/a (wires only).
// Backpressure: the controller may only launch a start while ready is high.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             done;

    // controller side
    modport master (
        output start, a, b, bin,
        input  ready, diff, bout, done
    );

    // subtractor side
    modport slave (
        input  start, a, b, bin,
        output ready, diff, bout, done
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one full-subtractor step per clock.
// Latency: done pulses in the cycle after edge E0+WIDTH+1 (E0 = accepting edge); next start at E0+WIDTH+3.
// Backpressure: ready is low from acceptance until back in IDLE; start while busy is dropped, not queued.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   sif
);
    localparam int CW = $clog2(WIDTH + 1);
    // The counter runs 0..WIDTH: WIDTH bit steps, then one step that commits the result.
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] r_q;
    logic             br_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;

    // One full-subtractor cell working on the current LSBs and the running borrow.
    logic a0, b0, d_bit, br_next;
    assign a0      = a_q[0];
    assign b0      = b_q[0];
    assign d_bit   = a0 ^ b0 ^ br_q;
    assign br_next = (~a0 & b0) | (~(a0 ^ b0) & br_q);

    // Outputs are pure functions of registers: no input-to-output combinational path.
    assign sif.ready = (state_q == IDLE);
    assign sif.done  = (state_q == DONE);
    assign sif.diff  = diff_q;
    assign sif.bout  = bout_q;

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sif.start)     state_d = SHIFT;
            SHIFT:   if (cnt_q == LAST) state_d = DONE;
            DONE:                       state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // State, datapath shift registers and held result; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (sif.start) begin
                        a_q   <= sif.a;
                        b_q   <= sif.b;
                        br_q  <= sif.bin;
                        cnt_q <= '0;
                    end
                end
                SHIFT: begin
                    if (cnt_q != LAST) begin
                        a_q   <= a_q >> 1;
                        b_q   <= b_q >> 1;
                        r_q   <= {d_bit, r_q[WIDTH-1:1]};
                        br_q  <= br_next;
                        cnt_q <= cnt_q + CW'(1);
                    end else begin
                        // All bits done: publish on the edge that enters DONE.
                        diff_q <= r_q;
                        bout_q <= br_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
